seq_udivider: RTL and testbench

- Multi-cycle unsigned integer divider: computes q = x / y and r = x % y using a radix-2 restoring (shift/subtract) algorithm, one quotient bit per clock, MSB first.
- Used wherever a small, area-cheap divider is acceptable in exchange for WIDTH-cycle latency.
- Has a start/busy/val handshake and a divide-by-zero flag.

---
 rtl/seq_udivider_if.sv | 26 ++
 rtl/seq_udivider.sv | 136 +++++++++++++
 tb/tb_seq_udivider.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/seq_udivider_if.sv
// Handshake and operand/result bundle for the sequential unsigned divider.
// The requester drives start/x/y; the divider returns status and results.
interface seq_udivider_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic             busy;
  logic             val;
  logic             dbz;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;

  modport master (
    output start, x, y,
    input  busy, val, dbz, q, r
  );

  modport slave (
    input  start, x, y,
    output busy, val, dbz, q, r
  );

endinterface

// File: rtl/seq_udivider.sv
// Radix-2 restoring unsigned divider: one quotient bit per clock, MSB first.
// A request is accepted only while idle; a zero divisor completes at once
// with the dbz flag instead of iterating.
module seq_udivider #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  seq_udivider_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] r_reg;
  logic             val_reg;
  logic             dbz_reg;

  logic             busy_int;
  logic             accept;
  logic             zero_req;
  logic             last_step;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] dvd_nxt;
  logic [WIDTH-1:0] rem_nxt;

  // State register; reset aborts any division in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: enter RUN on a valid request, leave after the last step.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept)    state_nxt = RUN;
      RUN:  if (last_step) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  // FSM outputs: busy flag plus the control strobes used by the datapath.
  always_comb begin
    busy_int  = 1'b0;
    accept    = 1'b0;
    zero_req  = 1'b0;
    last_step = 1'b0;
    case (state)
      IDLE: begin
        accept   = bus.start && (bus.y != '0);
        zero_req = bus.start && (bus.y == '0);
      end
      RUN: begin
        busy_int  = 1'b1;
        last_step = (cnt == CW'(1));
      end
      default: begin
        busy_int = 1'b0;
      end
    endcase
  end

  // One restoring step: shift in the next dividend bit, trial-subtract with
  // a WIDTH+1 bit difference, keep it if non-negative, and record the bit.
  always_comb begin
    shifted = {rem, dvd[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
    if (!diff[WIDTH]) begin
      rem_nxt = diff[WIDTH-1:0];
      dvd_nxt = {dvd[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = shifted[WIDTH-1:0];
      dvd_nxt = {dvd[WIDTH-2:0], 1'b0};
    end
  end

  // Datapath: operand capture, iteration, and result/flag registers.
  // The dividend register doubles as the quotient accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd     <= '0;
      dvs     <= '0;
      rem     <= '0;
      cnt     <= '0;
      q_reg   <= '0;
      r_reg   <= '0;
      val_reg <= 1'b0;
      dbz_reg <= 1'b0;
    end else if (accept) begin
      dvd     <= bus.x;
      dvs     <= bus.y;
      rem     <= '0;
      cnt     <= CW'(WIDTH);
      val_reg <= 1'b0;
      dbz_reg <= 1'b0;
    end else if (zero_req) begin
      q_reg   <= '1;
      r_reg   <= bus.x;
      val_reg <= 1'b0;
      dbz_reg <= 1'b1;
    end else if (state == RUN) begin
      dvd <= dvd_nxt;
      rem <= rem_nxt;
      cnt <= cnt - CW'(1);
      if (last_step) begin
        q_reg   <= dvd_nxt;
        r_reg   <= rem_nxt;
        val_reg <= 1'b1;
      end
    end
  end

  assign bus.busy = busy_int;
  assign bus.val  = val_reg;
  assign bus.dbz  = dbz_reg;
  assign bus.q    = q_reg;
  assign bus.r    = r_reg;

endmodule

// File: tb/tb_seq_udivider.sv
// Self-checking bench for seq_udivider: directed cases from the test plan
// followed by random divisions, compared against plain x / y and x % y.
module tb_seq_udivider;

  localparam int W = 8;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  // Reference model: result registers as the spec defines them.
  logic [W-1:0] exp_q;
  logic [W-1:0] exp_r;
  logic         exp_val;
  logic         exp_dbz;

  seq_udivider_if #(.WIDTH(W)) bus ();

  seq_udivider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, first rising edge at 5.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic checkState(input string tag, input logic exp_busy);
    checkOutput({tag, ".busy"}, {31'd0, bus.busy}, {31'd0, exp_busy});
    checkOutput({tag, ".val"},  {31'd0, bus.val},  {31'd0, exp_val});
    checkOutput({tag, ".dbz"},  {31'd0, bus.dbz},  {31'd0, exp_dbz});
    checkOutput({tag, ".q"},    {24'd0, bus.q},    {24'd0, exp_q});
    checkOutput({tag, ".r"},    {24'd0, bus.r},    {24'd0, exp_r});
  endtask

  // Issue one request at the current falling edge and follow it to
  // completion; returns on the falling edge after the result appears, so
  // consecutive calls exercise back-to-back acceptance.
  task automatic applyStimulus(input string tag, input logic [W-1:0] a,
                               input logic [W-1:0] b, input bit pulse);
    bus.start = 1'b1;
    bus.x     = a;
    bus.y     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.x     = W'($urandom);
    bus.y     = W'($urandom);
    if (b == '0) begin
      exp_q   = '1;
      exp_r   = a;
      exp_val = 1'b0;
      exp_dbz = 1'b1;
      checkState({tag, ".dbz"}, 1'b0);
      return;
    end
    exp_val = 1'b0;
    exp_dbz = 1'b0;
    for (int k = 1; k <= W; k++) begin
      checkState({tag, ".run"}, 1'b1);
      if (pulse && k == 3) begin
        bus.start = 1'b1;
        bus.x     = W'($urandom);
        bus.y     = W'($urandom_range(1, 255));
      end
      @(negedge clk);
      bus.start = 1'b0;
    end
    exp_q   = a / b;
    exp_r   = a % b;
    exp_val = 1'b1;
    exp_dbz = 1'b0;
    checkState({tag, ".done"}, 1'b0);
  endtask

  initial begin
    logic [W-1:0] rx;
    logic [W-1:0] ry;

    rst       = 1'b0;
    bus.start = 1'b0;
    bus.x     = '0;
    bus.y     = '0;

    // Asynchronous reset before any clock edge.
    #1 rst = 1'b1;
    #1;
    exp_q   = '0;
    exp_r   = '0;
    exp_val = 1'b0;
    exp_dbz = 1'b0;
    checkState("reset", 1'b0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus("div11_3",   8'd11,  8'd3,   1'b0);
    applyStimulus("div10_0",   8'd10,  8'd0,   1'b0);
    applyStimulus("div55_11",  8'd55,  8'd11,  1'b0);
    applyStimulus("div248_254", 8'd248, 8'd254, 1'b0);
    applyStimulus("busyprot",  8'd200, 8'd7,   1'b1);
    applyStimulus("div255_1",  8'd255, 8'd1,   1'b0);

    // Reset in the middle of a division: immediate clear, no result later.
    bus.start = 1'b1;
    bus.x     = 8'd100;
    bus.y     = 8'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    exp_q   = '0;
    exp_r   = '0;
    exp_val = 1'b0;
    exp_dbz = 1'b0;
    checkState("midreset", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checkState("aborted", 1'b0);

    // Random operands, including occasional zero divisors.
    for (int i = 0; i < 24; i++) begin
      rx = W'($urandom);
      ry = W'($urandom);
      if ($urandom_range(0, 5) == 0) ry = '0;
      if ($urandom_range(0, 7) == 0) ry = 8'd1;
      applyStimulus("rand", rx, ry, ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
